// File: rtl/spi_word_master_pkg.sv
// Shared constants and the FSM state type for the motor-controller SPI word protocol.
// Word width, byte order and header position match the target-side word handler.
package spi_word_master_pkg;

    localparam int SPI_WORD_BITS      = 64;
    localparam bit SPI_LSB_BYTE_FIRST = 1'b1;
    localparam int CMD_HDR_MSB        = 63;
    localparam int CMD_HDR_LSB        = 56;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_HOLD     = 3'd3,
        ST_GAP      = 3'd4
    } spi_state_t;

endpackage

// File: rtl/spi_word_master.sv
// Purpose: SPI mode-0 initiator, one full-duplex WORD_BITS word per CS-low frame, bytes LSB-first, bits MSB-first.
// Latency: CS low for WORD_BITS*2*CLK_DIV+CLK_DIV cycles from the cycle after accept; rx_valid on the first CS-high cycle.
// Backpressure: tx_ready only in IDLE; the word is captured on tx_valid & tx_ready and tx_data is ignored until the next IDLE.
module spi_word_master
    import spi_word_master_pkg::*;
#(
    parameter int CLK_DIV   = 4,
    parameter int WORD_BITS = SPI_WORD_BITS,
    parameter int CS_GAP    = 2
) (
    input  logic                 CLK,
    input  logic                 resetn,
    input  logic [WORD_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [WORD_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 busy,
    output logic                 SCK,
    output logic                 CS,
    output logic                 COPI,
    input  logic                 CIPO
);

    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(WORD_BITS);
    localparam int GW = (CS_GAP < 1) ? 1 : $clog2(CS_GAP + 1);

    localparam logic [HW-1:0] HC_LAST = HW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BC_LAST = BW'(WORD_BITS - 1);
    localparam logic [GW-1:0] GC_LAST = (CS_GAP < 1) ? '0 : GW'(CS_GAP - 1);

    spi_state_t state, state_nxt;

    logic [HW-1:0]        hc;
    logic [BW-1:0]        bc;
    logic [GW-1:0]        gc;
    logic [WORD_BITS-1:0] tx_sr;
    logic [WORD_BITS-1:0] rx_sr;
    logic [BW-1:0]        bit_idx;
    logic                 hc_done;
    logic                 in_frame;
    logic                 accept;

    // Serial bit k lives at word bit 8*(k/8)+7-(k%8): keep the byte index, mirror the bit-in-byte.
    assign bit_idx  = {bc[BW-1:3], ~bc[2:0]};
    assign hc_done  = (hc == HC_LAST);
    assign in_frame = (state == ST_SHIFT_LO) || (state == ST_SHIFT_HI) || (state == ST_HOLD);
    assign accept   = tx_valid && tx_ready;

    assign tx_ready = resetn && (state == ST_IDLE);
    assign busy     = resetn && (state != ST_IDLE);
    assign CS       = !in_frame;
    assign SCK      = (state == ST_SHIFT_HI);
    assign COPI     = in_frame && tx_sr[bit_idx];

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:     if (accept)  state_nxt = ST_SHIFT_LO;
            ST_SHIFT_LO: if (hc_done) state_nxt = ST_SHIFT_HI;
            ST_SHIFT_HI: if (hc_done) state_nxt = (bc == BC_LAST) ? ST_HOLD : ST_SHIFT_LO;
            ST_HOLD:     if (hc_done) state_nxt = ST_GAP;
            ST_GAP:      if (gc == GC_LAST) state_nxt = ST_IDLE;
            default:     state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!resetn) begin
            state    <= ST_IDLE;
            hc       <= '0;
            bc       <= '0;
            gc       <= '0;
            tx_sr    <= '0;
            rx_sr    <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else begin
            state    <= state_nxt;
            rx_valid <= 1'b0;

            if (in_frame && !hc_done) hc <= hc + 1'b1;
            else                      hc <= '0;

            if (state == ST_GAP) gc <= gc + 1'b1;
            else                 gc <= '0;

            if (accept) begin
                tx_sr <= tx_data;
                bc    <= '0;
            end

            // CIPO is sampled on the same edge that raises SCK.
            if (state == ST_SHIFT_LO && hc_done) rx_sr[bit_idx] <= CIPO;

            if (state == ST_SHIFT_HI && hc_done && bc != BC_LAST) bc <= bc + 1'b1;

            if (state == ST_HOLD && hc_done) begin
                rx_data  <= rx_sr;
                rx_valid <= 1'b1;
            end
        end
    end

endmodule
